// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge: FSM states, the APB
// window base and the per-slave address nibbles.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apbState_e;

  localparam logic [15:0] APB_BASE   = 16'h1000;
  localparam int          NUM_SLAVES = 4;

  // addr[15:12] value that selects each slave inside the APB window
  localparam logic [3:0] SLAVE_NIBBLE [NUM_SLAVES] = '{4'h0, 4'h1, 4'h2, 4'h3};

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of core-side request signals and APB bus signals for the bridge.
// The master modport is the bridge's view; slave is the core/peripheral side.
interface apb_master_bridge_if;

  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic [31:0] PRDATA3;
  logic [3:0]  PREADY;

  modport master (
    input  transfer, write, addr, wdata,
    output rdata, ready, err,
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );

  modport slave (
    output transfer, write, addr, wdata,
    input  rdata, ready, err,
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Decodes the upper address bits into a one-hot APB slave select; anything
// outside the 0x1000_xxxx window or past the last slave is a decode error.
module apb_addr_decoder
  import apb_master_bridge_pkg::*;
(
  input  logic [31:12]          i_addr,
  output logic [NUM_SLAVES-1:0] o_psel,
  output logic                  o_decErr
);

  always_comb begin
    o_psel = '0;
    if (i_addr[31:16] == APB_BASE) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (i_addr[15:12] == SLAVE_NIBBLE[i]) o_psel[i] = 1'b1;
      end
    end
  end

  assign o_decErr = ~|o_psel;

endmodule

// File: rtl/apb_master_bridge.sv
// Core-to-APB master bridge: IDLE/SETUP/ACCESS sequencer with latched request.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic                clk,
  input  logic                reset,
  apb_master_bridge_if.master bus
);

  apbState_e   r_state;
  apbState_e   w_nextState;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;

  logic [3:0]  w_psel;
  logic        w_decErr;
  logic        w_selReady;
  logic [31:0] w_selData;
  logic        w_timeout;
  logic        w_done;
  logic        w_fail;

  apb_addr_decoder u_decoder (
    .i_addr   (r_paddr[31:12]),
    .o_psel   (w_psel),
    .o_decErr (w_decErr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Request is captured only on acceptance so the bus stays stable until IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (r_state == IDLE && bus.transfer) begin
      r_paddr  <= bus.addr;
      r_pwdata <= bus.wdata;
      r_pwrite <= bus.write;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_waitCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_waitCnt <= '0;
    else if (r_state == SETUP)                r_waitCnt <= '0;
    else if (r_state == ACCESS && !w_selReady) r_waitCnt <= r_waitCnt + CNT_W'(1);
  end

  assign w_timeout = (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unusedTimeoutCfg;
  assign w_unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout          = 1'b0;
`endif

  assign w_selReady = |(bus.PREADY & w_psel);
  assign w_done     = (r_state == ACCESS) && (w_selReady || w_decErr || w_timeout);
  assign w_fail     = w_decErr || (w_timeout && !w_selReady);

  always_comb begin
    unique case (w_psel)
      4'b0001: w_selData = bus.PRDATA0;
      4'b0010: w_selData = bus.PRDATA1;
      4'b0100: w_selData = bus.PRDATA2;
      4'b1000: w_selData = bus.PRDATA3;
      default: w_selData = '0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (bus.transfer) w_nextState = SETUP;
      SETUP:   w_nextState = ACCESS;
      ACCESS:  if (w_done) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.PSEL    = '0;
    bus.PENABLE = 1'b0;
    bus.ready   = 1'b0;
    bus.err     = 1'b0;
    bus.rdata   = '0;
    if (r_state != IDLE) bus.PSEL = w_psel;
    if (r_state == ACCESS) begin
      bus.PENABLE = 1'b1;
      if (w_done) begin
        bus.ready = 1'b1;
        bus.err   = w_fail;
        if (!w_fail && !r_pwrite) bus.rdata = w_selData;
      end
    end
  end

  assign bus.PADDR  = r_paddr;
  assign bus.PWDATA = r_pwdata;
  assign bus.PWRITE = r_pwrite;

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the ACCESS-phase wait limit; it is used only when APB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 transfer  input  1  core data request; held high by the core until ready.
REQ-005 write  input  1  1 = store, 0 = load.
REQ-006 addr  input  32  byte address from the core (dataAddr).
REQ-007 wdata  input  32  store data from the core (dataWData).
REQ-008 rdata  output  32  load data returned to the core (dataRData).
REQ-009 ready  output  1  one-cycle transfer-complete pulse.
REQ-010 err  output  1  one-cycle error flag, valid with ready.
REQ-011 PADDR, PWDATA  output  32 each  latched APB address and write data.
REQ-012 PWRITE, PENABLE  output  1 each  APB direction and access-phase strobe.
REQ-013 PSEL  output  4  one-hot slave select.
REQ-014 PRDATA0..PRDATA3  input  32 each  per-slave read data.
REQ-015 PREADY  input  4  per-slave ready.

Function
REQ-016 FSM states SHALL be IDLE, SETUP and ACCESS.
- IDLE -> SETUP when transfer=1.
- SETUP -> ACCESS unconditionally.
- ACCESS -> IDLE when the selected PREADY=1 or an error is raised; otherwise the FSM stays in ACCESS.
REQ-017 In IDLE with transfer=1, addr, wdata and write SHALL be latched into PADDR, PWDATA and PWRITE; these outputs SHALL then hold stable until the FSM returns to IDLE.
REQ-018 Address decode on the latched address, with addr[31:16] required to equal 0x1000:
- addr[15:12] = 0..3 selects PSEL[0..3].
- Any other address is a decode error.
REQ-019 In SETUP: PSEL = decoded one-hot, PENABLE = 0. In ACCESS: PSEL unchanged, PENABLE = 1. In IDLE: PSEL = 0, PENABLE = 0.
REQ-020 In ACCESS, when the selected PREADY=1, the block SHALL, in the same cycle:
- assert ready=1 combinationally;
- drive rdata = selected PRDATA for reads, or 0 for writes.
REQ-021 On a decode error, PSEL SHALL stay 0 in SETUP and ACCESS, and the first ACCESS cycle SHALL give ready=1, err=1 and rdata=0.
REQ-022 Transfer changes while in SETUP or ACCESS SHALL be ignored.
- Minimum latency is 3 cycles from transfer accepted to the next accept: IDLE, SETUP, ACCESS.
- Back-to-back transfers SHALL pass through IDLE.
REQ-023 ready and err SHALL be 0 in every cycle other than the completing ACCESS cycle.
REQ-024 PREADY bits of unselected slaves SHALL have no effect.

Reset
REQ-025 While reset=1 (asynchronous), the block SHALL hold:
- FSM state = IDLE;
- PADDR = PWDATA = 0;
- PWRITE = PENABLE = 0, PSEL = 0;
- ready = err = 0, rdata = 0.
REQ-026 A reset asserted mid-transfer SHALL abort the transfer with no ready pulse; the core reissues the request after reset.

Configuration
REQ-027 The macro APB_TIMEOUT_EN SHALL control the ACCESS-phase timeout.
- Defined: a wait counter clears on SETUP entry and increments each ACCESS cycle with PREADY low. When it reaches TIMEOUT_CYCLES-1, the block SHALL complete with ready=1, err=1, rdata=0 and return to IDLE.
- Undefined: no counter exists, ACCESS waits indefinitely, and err is raised only on decode errors.

Structure
REQ-028 The shared package SHALL hold:
- the FSM state enum;
- the APB base constant 0x1000;
- the slave-count constant 4;
- the per-slave address-nibble constants.
REQ-029 The address decoder SHALL be a sub-module named apb_addr_decoder (addr in; one-hot PSEL and decode-error flag out).

Verification
REQ-030 Write to 0x1000_1004, data 0xDEAD_BEEF, PREADY[1] high in the first ACCESS cycle -> the following hold:
- SETUP has PSEL=4'b0010, PENABLE=0;
- ACCESS has PENABLE=1, PWDATA=0xDEAD_BEEF;
- ready pulses at cycle 3 with err=0.
REQ-031 Read from 0x1000_3000, PRDATA3=0x1234_5678, PREADY[3] held low 2 ACCESS cycles then high -> ready is asserted once with rdata=0x1234_5678, and PADDR is stable throughout.
REQ-032 Access to 0x2000_0000 -> the following hold:
- PSEL stays 0 throughout;
- ready=1, err=1, rdata=0 in the ACCESS cycle.
REQ-033 With APB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, read from slave 0 with PREADY[0] never asserted -> ready=1 and err=1 after 16 ACCESS cycles, and the FSM returns to IDLE.
REQ-034 Reset asserted during ACCESS of a write to slave 2 -> the following hold:
- all outputs are 0 immediately, without waiting for a clock edge;
- no ready pulse occurs;
- after release, a new transfer completes normally.
